// File: rtl/blockram_arbiter_if.sv
// Bus bundle between the two RAM requesters, the arbiter and the single-port blockram.
// The arbiter connects through the slave modport; the requesters and the RAM use the master modport.
interface blockram_arbiter_if #(
  parameter int ADDR_W = 32
);
  logic              p0_req;
  logic              p0_we;
  logic [3:0]        p0_be;
  logic [ADDR_W-1:0] p0_addr;
  logic [31:0]       p0_wdata;
  logic              p0_gnt;
  logic              p0_rvalid;
  logic [31:0]       p0_rdata;

  logic              p1_req;
  logic              p1_we;
  logic [3:0]        p1_be;
  logic [ADDR_W-1:0] p1_addr;
  logic [31:0]       p1_wdata;
  logic              p1_gnt;
  logic              p1_rvalid;
  logic [31:0]       p1_rdata;

  logic [ADDR_W-1:0] ram_addr;
  logic [3:0]        ram_be;
  logic [31:0]       ram_wdata;
  logic              ram_we;
  logic [31:0]       ram_rdata;

  modport slave (
    input  p0_req, p0_we, p0_be, p0_addr, p0_wdata,
    output p0_gnt, p0_rvalid, p0_rdata,
    input  p1_req, p1_we, p1_be, p1_addr, p1_wdata,
    output p1_gnt, p1_rvalid, p1_rdata,
    output ram_addr, ram_be, ram_wdata, ram_we,
    input  ram_rdata
  );

  modport master (
    output p0_req, p0_we, p0_be, p0_addr, p0_wdata,
    input  p0_gnt, p0_rvalid, p0_rdata,
    output p1_req, p1_we, p1_be, p1_addr, p1_wdata,
    input  p1_gnt, p1_rvalid, p1_rdata,
    input  ram_addr, ram_be, ram_wdata, ram_we,
    output ram_rdata
  );
endinterface

// File: rtl/blockram_arbiter.sv
// Two-port fixed-priority arbiter (CPU first) for the single-port data blockram, with a
// starvation counter for port 1. Optional saturating statistics counters under ARB_STATS_EN.
module blockram_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int STARVE_LIMIT = 8,
  parameter int CNT_W        = 8
) (
  input  logic                 clk,
  input  logic                 resetn,
  blockram_arbiter_if.slave    bus
`ifdef ARB_STATS_EN
  ,
  output logic [15:0]          stat_p0_grants,
  output logic [15:0]          stat_p1_grants,
  output logic [15:0]          stat_conflicts
`endif
);

  localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_P0   = 2'd1,
    OWN_P1   = 2'd2
  } rd_owner_t;

  logic             gnt0_s;
  logic             gnt1_s;
  logic [CNT_W-1:0] starve_cnt_r;
  rd_owner_t        rd_owner_r;
  rd_owner_t        rd_owner_next_s;

  function automatic logic [15:0] sat_inc16(input logic [15:0] val, input logic en);
    if (en && (val != 16'hFFFF)) begin
      return val + 16'd1;
    end else begin
      return val;
    end
  endfunction

  // Grant decision; port 1 only wins a conflict once it has waited STARVE_LIMIT cycles.
  always_comb begin
    gnt0_s = 1'b0;
    gnt1_s = 1'b0;
    if (!resetn) begin
      gnt0_s = 1'b0;
      gnt1_s = 1'b0;
    end else if (bus.p0_req && bus.p1_req) begin
      if (starve_cnt_r == LIMIT_C) begin
        gnt1_s = 1'b1;
      end else begin
        gnt0_s = 1'b1;
      end
    end else if (bus.p0_req) begin
      gnt0_s = 1'b1;
    end else if (bus.p1_req) begin
      gnt1_s = 1'b1;
    end else begin
      gnt0_s = 1'b0;
      gnt1_s = 1'b0;
    end
  end

  assign bus.p0_gnt    = gnt0_s;
  assign bus.p1_gnt    = gnt1_s;
  assign bus.ram_addr  = gnt1_s ? bus.p1_addr  : bus.p0_addr;
  assign bus.ram_be    = gnt1_s ? bus.p1_be    : bus.p0_be;
  assign bus.ram_wdata = gnt1_s ? bus.p1_wdata : bus.p0_wdata;
  assign bus.ram_we    = (gnt0_s & bus.p0_we) | (gnt1_s & bus.p1_we);
  assign bus.p0_rdata  = bus.ram_rdata;
  assign bus.p1_rdata  = bus.ram_rdata;

  // Starvation counter: counts consecutive denied port-1 cycles, saturating at the limit.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      starve_cnt_r <= {CNT_W{1'b0}};
    end else if (bus.p1_req && !gnt1_s) begin
      if (starve_cnt_r == LIMIT_C) begin
        starve_cnt_r <= starve_cnt_r;
      end else begin
        starve_cnt_r <= starve_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end else begin
      starve_cnt_r <= {CNT_W{1'b0}};
    end
  end

  // Read-return owner for the following cycle (the RAM has one cycle of read latency).
  always_comb begin
    rd_owner_next_s = OWN_NONE;
    if (gnt0_s && !bus.p0_we) begin
      rd_owner_next_s = OWN_P0;
    end else if (gnt1_s && !bus.p1_we) begin
      rd_owner_next_s = OWN_P1;
    end else begin
      rd_owner_next_s = OWN_NONE;
    end
  end

  // Read-return owner register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rd_owner_r <= OWN_NONE;
    end else begin
      rd_owner_r <= rd_owner_next_s;
    end
  end

  // Decode owner into per-port rvalid.
  always_comb begin
    bus.p0_rvalid = 1'b0;
    bus.p1_rvalid = 1'b0;
    case (rd_owner_r)
      OWN_P0:   bus.p0_rvalid = 1'b1;
      OWN_P1:   bus.p1_rvalid = 1'b1;
      OWN_NONE: bus.p0_rvalid = 1'b0;
      default:  bus.p1_rvalid = 1'b0;
    endcase
  end

`ifdef ARB_STATS_EN
  // Saturating grant and conflict statistics for the debug/LED logic.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      stat_p0_grants <= 16'd0;
      stat_p1_grants <= 16'd0;
      stat_conflicts <= 16'd0;
    end else begin
      stat_p0_grants <= sat_inc16(stat_p0_grants, gnt0_s);
      stat_p1_grants <= sat_inc16(stat_p1_grants, gnt1_s);
      stat_conflicts <= sat_inc16(stat_conflicts, bus.p0_req & bus.p1_req);
    end
  end
`endif

endmodule

// File: tb/tb_blockram_arbiter.sv
// Directed testbench for blockram_arbiter with a behavioural 1-cycle-latency blockram.
// Statistics checks are compiled in when ARB_STATS_EN is defined.
module tb_blockram_arbiter;

  logic clk;
  logic resetn;
  int   tests_run;
  int   tests_failed;
  logic [31:0] mem [0:255];

  blockram_arbiter_if #(.ADDR_W(32)) bus ();

`ifdef ARB_STATS_EN
  logic [15:0] stat_p0_grants;
  logic [15:0] stat_p1_grants;
  logic [15:0] stat_conflicts;
`endif

  blockram_arbiter #(
    .ADDR_W      (32),
    .STARVE_LIMIT(8),
    .CNT_W       (8)
  ) dut (
    .clk   (clk),
    .resetn(resetn),
    .bus   (bus)
`ifdef ARB_STATS_EN
    ,
    .stat_p0_grants(stat_p0_grants),
    .stat_p1_grants(stat_p1_grants),
    .stat_conflicts(stat_conflicts)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural blockram: byte-enabled write, registered read.
  always @(posedge clk) begin
    if (bus.ram_we) begin
      for (int b = 0; b < 4; b++) begin
        if (bus.ram_be[b]) mem[bus.ram_addr[7:0]][8*b +: 8] <= bus.ram_wdata[8*b +: 8];
      end
    end
    bus.ram_rdata <= mem[bus.ram_addr[7:0]];
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic drive_p0(input logic req, input logic we, input logic [3:0] be,
                          input logic [31:0] addr, input logic [31:0] wdata);
    bus.p0_req = req; bus.p0_we = we; bus.p0_be = be; bus.p0_addr = addr; bus.p0_wdata = wdata;
  endtask

  task automatic drive_p1(input logic req, input logic we, input logic [3:0] be,
                          input logic [31:0] addr, input logic [31:0] wdata);
    bus.p1_req = req; bus.p1_we = we; bus.p1_be = be; bus.p1_addr = addr; bus.p1_wdata = wdata;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    for (int i = 0; i < 256; i++) mem[i] = 32'h0000_0000;
    mem[8'h10] = 32'hDEAD_BEEF;
    mem[8'h11] = 32'hA5A5_0011;
    mem[8'h20] = 32'hFFFF_FFFF;
    bus.ram_rdata = 32'h0000_0000;

    // Reset with both ports requesting
    resetn = 1'b0;
    drive_p0(1'b1, 1'b1, 4'hF, 32'h0000_00F0, 32'h0000_0000);
    drive_p1(1'b1, 1'b0, 4'hF, 32'h0000_0011, 32'h0000_0000);
    tick();
    tick();
    check_eq("rst_p0_gnt",    {31'd0, bus.p0_gnt},    32'd0);
    check_eq("rst_p1_gnt",    {31'd0, bus.p1_gnt},    32'd0);
    check_eq("rst_ram_we",    {31'd0, bus.ram_we},    32'd0);
    check_eq("rst_p0_rvalid", {31'd0, bus.p0_rvalid}, 32'd0);
    check_eq("rst_p1_rvalid", {31'd0, bus.p1_rvalid}, 32'd0);
    resetn = 1'b1;
    #1;
    check_eq("rel_p0_gnt", {31'd0, bus.p0_gnt}, 32'd1);
    check_eq("rel_p1_gnt", {31'd0, bus.p1_gnt}, 32'd0);
    drive_p0(1'b0, 1'b0, 4'hF, 32'h0000_0010, 32'h0000_0000);
    drive_p1(1'b0, 1'b0, 4'hF, 32'h0000_0010, 32'h0000_0000);
    tick();

    // Solo read on port 1
    drive_p1(1'b1, 1'b0, 4'hF, 32'h0000_0010, 32'h0000_0000);
    #1;
    check_eq("solo_p1_gnt",   {31'd0, bus.p1_gnt}, 32'd1);
    check_eq("solo_p0_gnt",   {31'd0, bus.p0_gnt}, 32'd0);
    check_eq("solo_ram_we",   {31'd0, bus.ram_we}, 32'd0);
    check_eq("solo_ram_addr", bus.ram_addr,        32'h0000_0010);
    tick();
    drive_p1(1'b0, 1'b0, 4'hF, 32'h0000_0010, 32'h0000_0000);
    #1;
    check_eq("solo_p1_rvalid", {31'd0, bus.p1_rvalid}, 32'd1);
    check_eq("solo_p1_rdata",  bus.p1_rdata,           32'hDEAD_BEEF);
    check_eq("solo_p0_rvalid", {31'd0, bus.p0_rvalid}, 32'd0);
    tick();
    check_eq("solo_rvalid_drop", {31'd0, bus.p1_rvalid}, 32'd0);

    // Continuous contention: 8 port-0 grants then one port-1 grant, repeating
    drive_p0(1'b1, 1'b0, 4'hF, 32'h0000_0010, 32'h0000_0000);
    drive_p1(1'b1, 1'b0, 4'hF, 32'h0000_0011, 32'h0000_0000);
    for (int i = 0; i < 27; i++) begin
      #1;
      check_eq($sformatf("cont_p0_gnt_%0d", i), {31'd0, bus.p0_gnt}, (i % 9 == 8) ? 32'd0 : 32'd1);
      check_eq($sformatf("cont_p1_gnt_%0d", i), {31'd0, bus.p1_gnt}, (i % 9 == 8) ? 32'd1 : 32'd0);
      check_eq($sformatf("cont_cnt_%0d", i), {24'd0, dut.starve_cnt_r}, 32'(i % 9));
      if (i > 0) begin
        check_eq($sformatf("cont_p1_rv_%0d", i), {31'd0, bus.p1_rvalid}, ((i - 1) % 9 == 8) ? 32'd1 : 32'd0);
        check_eq($sformatf("cont_p0_rv_%0d", i), {31'd0, bus.p0_rvalid}, ((i - 1) % 9 == 8) ? 32'd0 : 32'd1);
        check_eq($sformatf("cont_rdata_%0d", i), bus.ram_rdata,
                 ((i - 1) % 9 == 8) ? 32'hA5A5_0011 : 32'hDEAD_BEEF);
      end
      tick();
    end
    drive_p0(1'b0, 1'b0, 4'hF, 32'h0000_0010, 32'h0000_0000);
    drive_p1(1'b0, 1'b0, 4'hF, 32'h0000_0011, 32'h0000_0000);
    tick();

    // Partial write on port 0, then read back on port 1
    drive_p0(1'b1, 1'b1, 4'b0011, 32'h0000_0020, 32'h1234_5678);
    #1;
    check_eq("wr_p0_gnt", {31'd0, bus.p0_gnt}, 32'd1);
    check_eq("wr_ram_we", {31'd0, bus.ram_we}, 32'd1);
    tick();
    drive_p0(1'b0, 1'b0, 4'hF, 32'h0000_0020, 32'h0000_0000);
    drive_p1(1'b1, 1'b0, 4'hF, 32'h0000_0020, 32'h0000_0000);
    #1;
    check_eq("rd_p1_gnt",       {31'd0, bus.p1_gnt},    32'd1);
    check_eq("wr_no_p0_rvalid", {31'd0, bus.p0_rvalid}, 32'd0);
    check_eq("wr_no_p1_rvalid", {31'd0, bus.p1_rvalid}, 32'd0);
    tick();
    drive_p1(1'b0, 1'b0, 4'hF, 32'h0000_0020, 32'h0000_0000);
    #1;
    check_eq("rd_p1_rvalid", {31'd0, bus.p1_rvalid}, 32'd1);
    check_eq("rd_p1_rdata",  bus.p1_rdata,           32'hFFFF_5678);
    tick();

    // Reset asserted after a read grant but before its edge
    drive_p0(1'b1, 1'b0, 4'hF, 32'h0000_0010, 32'h0000_0000);
    drive_p1(1'b1, 1'b0, 4'hF, 32'h0000_0011, 32'h0000_0000);
    #1;
    check_eq("mid_p0_gnt", {31'd0, bus.p0_gnt}, 32'd1);
    resetn = 1'b0;
    #1;
    check_eq("mid_gnt_forced", {30'd0, bus.p0_gnt, bus.p1_gnt}, 32'd0);
    tick();
    check_eq("mid_p0_rvalid", {31'd0, bus.p0_rvalid}, 32'd0);
    check_eq("mid_p1_rvalid", {31'd0, bus.p1_rvalid}, 32'd0);
    check_eq("mid_cnt",       {24'd0, dut.starve_cnt_r}, 32'd0);
    drive_p0(1'b0, 1'b0, 4'hF, 32'h0000_0010, 32'h0000_0000);
    drive_p1(1'b0, 1'b0, 4'hF, 32'h0000_0011, 32'h0000_0000);
    resetn = 1'b1;
    tick();

`ifdef ARB_STATS_EN
    // 20 contention cycles then 5 port-0-only cycles
    drive_p0(1'b1, 1'b0, 4'hF, 32'h0000_0010, 32'h0000_0000);
    drive_p1(1'b1, 1'b0, 4'hF, 32'h0000_0011, 32'h0000_0000);
    for (int i = 0; i < 20; i++) tick();
    drive_p1(1'b0, 1'b0, 4'hF, 32'h0000_0011, 32'h0000_0000);
    for (int i = 0; i < 5; i++) tick();
    drive_p0(1'b0, 1'b0, 4'hF, 32'h0000_0010, 32'h0000_0000);
    tick();
    check_eq("stat_conflicts", {16'd0, stat_conflicts}, 32'd20);
    check_eq("stat_p1_grants", {16'd0, stat_p1_grants}, 32'd2);
    check_eq("stat_p0_grants", {16'd0, stat_p0_grants}, 32'd23);
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
